wordle_guess_checker: RTL and testbench

- Scores one submitted guess against the secret target word and produces a per-position color (green/yellow/gray) plus a win flag.
- Sits downstream of wordle_keyboard/wordle_sm. wordle_sm pulses Start once a row's letters are complete; the results feed wordle_sm's win/lose decision and the VGA tile coloring.
- Uses a multi-cycle two-pass FSM so that duplicate letters are scored exactly as in Wordle.

---
 rtl/wordle_pkg.sv | 46 ++++
 rtl/wordle_guess_checker_if.sv | 36 +++
 rtl/wordle_match_finder.sv | 24 ++
 rtl/wordle_guess_checker.sv | 152 +++++++++++++++
 tb/tb_wordle_guess_checker.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wordle_pkg.sv
// Shared constants, state encoding and helpers for the Wordle guess checker.
// Optional build macro WORDLE_CHK_INVALID_EN enables the letter-range check.
package wordle_pkg;

    localparam int WORD_LEN   = 5;
    localparam int LETTER_W   = 5;
    localparam int LETTER_MAX = 25;
    localparam int POS_W      = $clog2(WORD_LEN);
    localparam int WORD_W     = WORD_LEN * LETTER_W;
    localparam int COLORS_W   = 2 * WORD_LEN;

    localparam logic [1:0] COLOR_GRAY   = 2'b00;
    localparam logic [1:0] COLOR_YELLOW = 2'b01;
    localparam logic [1:0] COLOR_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        ST_I      = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic [LETTER_W-1:0] letter_at(input logic [WORD_W-1:0] word,
                                                      input logic [POS_W-1:0]  pos);
        return word[LETTER_W*pos +: LETTER_W];
    endfunction

    function automatic logic all_green(input logic [COLORS_W-1:0] colors);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (colors[2*i +: 2] != COLOR_GREEN) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic has_invalid_letter(input logic [WORD_W-1:0] word);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (int'(word[LETTER_W*i +: LETTER_W]) > LETTER_MAX) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/wordle_guess_checker_if.sv
// Handshake and data bundle between the game controller and the guess checker.
// The invalid flag exists only when WORDLE_CHK_INVALID_EN is defined.
interface wordle_guess_checker_if;
    import wordle_pkg::*;

    logic                Start;
    logic                Ack;
    logic [WORD_W-1:0]   guess;
    logic [WORD_W-1:0]   target;
    logic [COLORS_W-1:0] colors;
    logic                win;
    logic                q_I;
    logic                q_Green;
    logic                q_Yellow;
    logic                q_Done;
`ifdef WORDLE_CHK_INVALID_EN
    logic                invalid;
`endif

    modport master (
        output Start, Ack, guess, target,
        input  colors, win, q_I, q_Green, q_Yellow, q_Done
`ifdef WORDLE_CHK_INVALID_EN
        , input invalid
`endif
    );

    modport slave (
        input  Start, Ack, guess, target,
        output colors, win, q_I, q_Green, q_Yellow, q_Done
`ifdef WORDLE_CHK_INVALID_EN
        , output invalid
`endif
    );

endinterface

// File: rtl/wordle_match_finder.sv
// Combinational search for the lowest unused target position holding a given letter.
module wordle_match_finder
    import wordle_pkg::*;
(
    input  logic [LETTER_W-1:0] letter,
    input  logic [WORD_W-1:0]   target,
    input  logic [WORD_LEN-1:0] used,
    output logic                found,
    output logic [WORD_LEN-1:0] match_onehot
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        found        = 1'b0;
        match_onehot = '0;
        for (int j = 0; j < WORD_LEN; j++) begin
            if (!found && !used[j] && target[LETTER_W*j +: LETTER_W] == letter) begin
                found           = 1'b1;
                match_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wordle_guess_checker.sv
// Two-pass (green then yellow) Wordle scorer; duplicates are resolved like the real game.
// Optional build macro WORDLE_CHK_INVALID_EN flags guesses with letter codes above 25.
module wordle_guess_checker
    import wordle_pkg::*;
(
    input  logic                   Clk,
    input  logic                   reset,
    wordle_guess_checker_if.slave  bus
);

    state_e              state_q,  state_d;
    logic [POS_W-1:0]    pos_q,    pos_d;
    logic [WORD_LEN-1:0] used_q,   used_d;
    logic [COLORS_W-1:0] colors_q, colors_d;
    logic                win_q,    win_d;
    logic [WORD_W-1:0]   guess_q,  guess_d;
    logic [WORD_W-1:0]   target_q, target_d;
`ifdef WORDLE_CHK_INVALID_EN
    logic                invalid_q, invalid_d;
`endif

    logic [LETTER_W-1:0] cur_guess;
    logic [LETTER_W-1:0] cur_target;
    logic                last_pos;
    logic                match_found;
    logic [WORD_LEN-1:0] match_onehot;

    assign cur_guess  = letter_at(guess_q, pos_q);
    assign cur_target = letter_at(target_q, pos_q);
    assign last_pos   = (pos_q == POS_W'(WORD_LEN - 1));

    wordle_match_finder u_match_finder (
        .letter       (cur_guess),
        .target       (target_q),
        .used         (used_q),
        .found        (match_found),
        .match_onehot (match_onehot)
    );

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        used_d   = used_q;
        colors_d = colors_q;
        win_d    = win_q;
        guess_d  = guess_q;
        target_d = target_q;
`ifdef WORDLE_CHK_INVALID_EN
        invalid_d = invalid_q;
`endif

        unique case (state_q)
            ST_I: begin
                if (bus.Start) begin
                    guess_d  = bus.guess;
                    target_d = bus.target;
                    colors_d = '0;
                    used_d   = '0;
                    win_d    = 1'b0;
                    pos_d    = '0;
                    state_d  = ST_GREEN;
`ifdef WORDLE_CHK_INVALID_EN
                    invalid_d = 1'b0;
`endif
                end
            end

            ST_GREEN: begin
`ifdef WORDLE_CHK_INVALID_EN
                // Range check runs on the latched guess in the first GREEN cycle.
                if (pos_q == '0 && has_invalid_letter(guess_q)) begin
                    invalid_d = 1'b1;
                    colors_d  = '0;
                    win_d     = 1'b0;
                    state_d   = ST_DONE;
                end else begin
`else
                begin
`endif
                    if (cur_guess == cur_target) begin
                        colors_d[2*pos_q +: 2] = COLOR_GREEN;
                        used_d[pos_q]          = 1'b1;
                    end
                    if (last_pos) begin
                        pos_d   = '0;
                        state_d = ST_YELLOW;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end
            end

            ST_YELLOW: begin
                if (colors_q[2*pos_q +: 2] != COLOR_GREEN && match_found) begin
                    colors_d[2*pos_q +: 2] = COLOR_YELLOW;
                    used_d                 = used_q | match_onehot;
                end
                if (last_pos) begin
                    pos_d   = '0;
                    win_d   = all_green(colors_d);
                    state_d = ST_DONE;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (bus.Ack) state_d = ST_I;
            end

            default: state_d = ST_I;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only; the next values come from always_comb.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q  <= ST_I;
            pos_q    <= '0;
            used_q   <= '0;
            colors_q <= '0;
            win_q    <= 1'b0;
            guess_q  <= '0;
            target_q <= '0;
`ifdef WORDLE_CHK_INVALID_EN
            invalid_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            used_q   <= used_d;
            colors_q <= colors_d;
            win_q    <= win_d;
            guess_q  <= guess_d;
            target_q <= target_d;
`ifdef WORDLE_CHK_INVALID_EN
            invalid_q <= invalid_d;
`endif
        end
    end

    assign bus.colors   = colors_q;
    assign bus.win      = win_q;
    assign bus.q_I      = (state_q == ST_I);
    assign bus.q_Green  = (state_q == ST_GREEN);
    assign bus.q_Yellow = (state_q == ST_YELLOW);
    assign bus.q_Done   = (state_q == ST_DONE);
`ifdef WORDLE_CHK_INVALID_EN
    assign bus.invalid  = invalid_q;
`endif

endmodule

// File: tb/tb_wordle_guess_checker.sv
// Directed self-checking bench for wordle_guess_checker (default build, range check disabled).
module tb_wordle_guess_checker;
    import wordle_pkg::*;

    logic Clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    wordle_guess_checker_if bus ();

    wordle_guess_checker dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] X = 2'b00;

    function automatic logic [WORD_W-1:0] w(input string s);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < WORD_LEN; i++) r[LETTER_W*i +: LETTER_W] = LETTER_W'(s[i] - 8'd65);
        return r;
    endfunction

    function automatic logic [COLORS_W-1:0] cols(input logic [1:0] c0, c1, c2, c3, c4);
        return {c4, c3, c2, c1, c0};
    endfunction

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic start_game(input logic [WORD_W-1:0] g, input logic [WORD_W-1:0] t);
        bus.guess  = g;
        bus.target = t;
        bus.Start  = 1'b1;
        step(1);
        bus.Start  = 1'b0;
    endtask

    task automatic ack_game();
        bus.Ack = 1'b1;
        step(1);
        bus.Ack = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.Start  = 1'b0;
        bus.Ack    = 1'b0;
        bus.guess  = '0;
        bus.target = '0;
        step(2);
        reset = 1'b0;
        n_checks++;
        if ({bus.q_I, bus.q_Green, bus.q_Yellow, bus.q_Done} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_state got=%b want=1000", {bus.q_I, bus.q_Green, bus.q_Yellow, bus.q_Done});
        end
        n_checks++;
        if (bus.colors !== '0 || bus.win !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs colors=%b win=%b want 0/0", bus.colors, bus.win);
        end
        step(2);
        n_checks++;
        if (bus.q_I !== 1'b1) begin
            n_fail++; $display("FAIL idle_hold q_I=%b want=1", bus.q_I);
        end
    endtask

    task automatic test_all_green();
        start_game(w("CRANE"), w("CRANE"));
        bus.guess  = w("ZZZZZ");
        bus.target = w("QQQQQ");
        n_checks++;
        if (bus.q_Green !== 1'b1) begin
            n_fail++; $display("FAIL green_entry q_Green=%b want=1", bus.q_Green);
        end
        step(9);
        n_checks++;
        if (bus.q_Done !== 1'b0 || bus.q_Yellow !== 1'b1) begin
            n_fail++; $display("FAIL latency_early q_Done=%b q_Yellow=%b want 0/1", bus.q_Done, bus.q_Yellow);
        end
        step(1);
        n_checks++;
        if (bus.q_Done !== 1'b1) begin
            n_fail++; $display("FAIL latency_done q_Done=%b want=1", bus.q_Done);
        end
        n_checks++;
        if (bus.colors !== cols(G, G, G, G, G) || bus.win !== 1'b1) begin
            n_fail++; $display("FAIL crane_crane colors=%b win=%b want=%b/1", bus.colors, bus.win, cols(G, G, G, G, G));
        end
        ack_game();
        n_checks++;
        if (bus.q_I !== 1'b1 || bus.colors !== cols(G, G, G, G, G) || bus.win !== 1'b1) begin
            n_fail++; $display("FAIL ack_hold q_I=%b colors=%b win=%b want 1/%b/1", bus.q_I, bus.colors, bus.win, cols(G, G, G, G, G));
        end
    endtask

    task automatic test_duplicates();
        start_game(w("BABES"), w("ABBEY"));
        n_checks++;
        if (bus.colors !== '0 || bus.win !== 1'b0) begin
            n_fail++; $display("FAIL start_clears colors=%b win=%b want 0/0", bus.colors, bus.win);
        end
        step(10);
        n_checks++;
        if (bus.q_Done !== 1'b1 || bus.colors !== cols(Y, Y, G, G, X) || bus.win !== 1'b0) begin
            n_fail++; $display("FAIL babes_abbey done=%b colors=%b win=%b want 1/%b/0", bus.q_Done, bus.colors, bus.win, cols(Y, Y, G, G, X));
        end
        ack_game();
    endtask

    task automatic test_green_consumes();
        start_game(w("EERIE"), w("CRANE"));
        step(10);
        n_checks++;
        if (bus.q_Done !== 1'b1 || bus.colors !== cols(X, X, Y, X, G) || bus.win !== 1'b0) begin
            n_fail++; $display("FAIL eerie_crane done=%b colors=%b win=%b want 1/%b/0", bus.q_Done, bus.colors, bus.win, cols(X, X, Y, X, G));
        end
        ack_game();
    endtask

    task automatic test_ignored_pulses();
        start_game(w("EERIE"), w("CRANE"));
        step(1);
        bus.guess  = w("CRANE");
        bus.target = w("CRANE");
        bus.Start  = 1'b1;
        bus.Ack    = 1'b1;
        step(1);
        bus.Start  = 1'b0;
        bus.Ack    = 1'b0;
        step(4);
        n_checks++;
        if (bus.q_Yellow !== 1'b1) begin
            n_fail++; $display("FAIL pulse_in_green q_Yellow=%b want=1", bus.q_Yellow);
        end
        bus.Start = 1'b1;
        step(1);
        bus.Start = 1'b0;
        step(3);
        n_checks++;
        if (bus.q_Done !== 1'b1 || bus.colors !== cols(X, X, Y, X, G)) begin
            n_fail++; $display("FAIL pulse_in_yellow done=%b colors=%b want 1/%b", bus.q_Done, bus.colors, cols(X, X, Y, X, G));
        end
        bus.Start = 1'b1;
        step(1);
        bus.Start = 1'b0;
        n_checks++;
        if (bus.q_Done !== 1'b1 || bus.colors !== cols(X, X, Y, X, G)) begin
            n_fail++; $display("FAIL start_in_done done=%b colors=%b want 1/%b", bus.q_Done, bus.colors, cols(X, X, Y, X, G));
        end
        ack_game();
        n_checks++;
        if (bus.q_I !== 1'b1 || bus.colors !== cols(X, X, Y, X, G)) begin
            n_fail++; $display("FAIL ack_to_idle q_I=%b colors=%b want 1/%b", bus.q_I, bus.colors, cols(X, X, Y, X, G));
        end
        start_game(w("CRANE"), w("CRANE"));
        n_checks++;
        if (bus.q_Green !== 1'b1 || bus.colors !== '0) begin
            n_fail++; $display("FAIL restart_clear q_Green=%b colors=%b want 1/0", bus.q_Green, bus.colors);
        end
        step(10);
        n_checks++;
        if (bus.win !== 1'b1 || bus.colors !== cols(G, G, G, G, G)) begin
            n_fail++; $display("FAIL restart_score win=%b colors=%b want 1/%b", bus.win, bus.colors, cols(G, G, G, G, G));
        end
        ack_game();
    endtask

    task automatic test_reset_mid_pass();
        start_game(w("BABES"), w("ABBEY"));
        step(7);
        n_checks++;
        if (bus.q_Yellow !== 1'b1) begin
            n_fail++; $display("FAIL mid_yellow q_Yellow=%b want=1", bus.q_Yellow);
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        n_checks++;
        if (bus.q_I !== 1'b1 || bus.colors !== '0 || bus.win !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid q_I=%b colors=%b win=%b want 1/0/0", bus.q_I, bus.colors, bus.win);
        end
        start_game(w("CRANE"), w("CRANE"));
        step(10);
        n_checks++;
        if (bus.q_Done !== 1'b1 || bus.win !== 1'b1 || bus.colors !== cols(G, G, G, G, G)) begin
            n_fail++; $display("FAIL after_reset done=%b win=%b colors=%b want 1/1/%b", bus.q_Done, bus.win, bus.colors, cols(G, G, G, G, G));
        end
        ack_game();
    endtask

    task automatic test_back_to_back();
        logic [WORD_W-1:0] g;
        logic [WORD_W-1:0] t;
        // Codes above 25 are compared as plain values.
        g = {5'd27, 5'd27, 5'd27, 5'd27, 5'd27};
        t = {5'd1, 5'd1, 5'd1, 5'd1, 5'd27};
        start_game(g, t);
        step(10);
        n_checks++;
        if (bus.colors !== cols(G, X, X, X, X) || bus.win !== 1'b0) begin
            n_fail++; $display("FAIL code27 colors=%b win=%b want %b/0", bus.colors, bus.win, cols(G, X, X, X, X));
        end
        ack_game();
        start_game(w("SPEED"), w("ERASE"));
        step(10);
        n_checks++;
        if (bus.q_Done !== 1'b1 || bus.colors !== cols(Y, X, Y, Y, X)) begin
            n_fail++; $display("FAIL speed_erase done=%b colors=%b want 1/%b", bus.q_Done, bus.colors, cols(Y, X, Y, Y, X));
        end
        ack_game();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_all_green();
        test_duplicates();
        test_green_consumes();
        test_ignored_pulses();
        test_reset_mid_pass();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
